// File: rtl/window_pkg.sv
// Shared definitions for the window averager: datapath widths, FSM states
// and the legal range of the window-length parameter.
package window_pkg;

  localparam int SAMPLE_W = 13;
  localparam int SUM_W    = 21;

  localparam int LOG2N_MIN = 1;
  localparam int LOG2N_MAX = 8;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    WAIT  = 2'd1,
    CAPT  = 2'd2
  } state_t;

  function automatic bit log2n_legal(input int n);
    return (n >= LOG2N_MIN) && (n <= LOG2N_MAX);
  endfunction

endpackage

// File: rtl/window_averager_if.sv
// Bundle between the sample source / summator side and the averager:
// master drives samples, sum and consumer ready; slave is the averager.
interface window_averager_if;
  import window_pkg::*;

  logic                       ce_in;
  logic signed [SUM_W-1:0]    y_in;
  logic                       stall;
  logic                       sum_clr;
  logic signed [SAMPLE_W-1:0] avg_out;
  logic                       avg_valid;
  logic                       avg_ready;
  logic [7:0]                 win_cnt;
  logic                       err_drop;
  logic                       err_ce;

  modport master (
    output ce_in, y_in, avg_ready,
    input  stall, sum_clr, avg_out, avg_valid, win_cnt, err_drop, err_ce
  );

  modport slave (
    input  ce_in, y_in, avg_ready,
    output stall, sum_clr, avg_out, avg_valid, win_cnt, err_drop, err_ce
  );

endinterface

// File: rtl/avg_scale.sv
// Combinational divide-by-2^LOG2N of the window sum down to sample width.
// WINDOW_AVERAGER_ROUND_EN selects round-half-up; otherwise floor.
module avg_scale
  import window_pkg::*;
#(
  parameter int LOG2N = 4
) (
  input  logic signed [SUM_W-1:0]    sum,
  output logic signed [SAMPLE_W-1:0] mean
);

`ifdef WINDOW_AVERAGER_ROUND_EN
  // One extra bit so adding the half-LSB bias cannot wrap the sum.
  localparam logic signed [SUM_W:0] HALF = (SUM_W+1)'(1) <<< (LOG2N - 1);

  logic signed [SUM_W:0] biased;

  always_comb begin
    biased = (SUM_W+1)'(sum) + HALF;
    mean   = SAMPLE_W'(biased >>> LOG2N);
  end
`else
  always_comb begin
    mean = SAMPLE_W'(sum >>> LOG2N);
  end
`endif

endmodule

// File: rtl/window_averager.sv
// Accumulate-and-dump controller for the running summator: counts samples,
// captures each 2^LOG2N window sum, clears the summator and emits the mean.
// Rounding mode is chosen in avg_scale by WINDOW_AVERAGER_ROUND_EN.
module window_averager
  import window_pkg::*;
#(
  parameter int LOG2N = 4
) (
  input  logic              clk,
  input  logic              rst,
  window_averager_if.slave  bus
);

  if (!log2n_legal(LOG2N)) begin : g_log2n_check
    $error("window_averager: LOG2N must be within 1..8");
  end

  localparam logic [LOG2N-1:0] CNT_LAST = '1;

  state_t                     state_q, state_d;
  logic [LOG2N-1:0]           cnt_q, cnt_d;
  logic                       stall_q, stall_d;
  logic                       sum_clr_q, sum_clr_d;
  logic signed [SAMPLE_W-1:0] avg_q, avg_d;
  logic                       avg_valid_q, avg_valid_d;
  logic [7:0]                 win_cnt_q, win_cnt_d;
  logic                       err_drop_q, err_drop_d;
  logic                       err_ce_q, err_ce_d;
  logic signed [SAMPLE_W-1:0] mean;

  avg_scale #(.LOG2N(LOG2N)) u_scale (
    .sum  (bus.y_in),
    .mean (mean)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_d     = stall_q;
    sum_clr_d   = sum_clr_q;
    avg_d       = avg_q;
    avg_valid_d = avg_valid_q;
    win_cnt_d   = win_cnt_q;
    err_drop_d  = err_drop_q;
    err_ce_d    = err_ce_q;

    // A pop is overridden below if a new result loads in the same cycle.
    if (avg_valid_q && bus.avg_ready) avg_valid_d = 1'b0;
    if (stall_q && bus.ce_in) err_ce_d = 1'b1;

    case (state_q)
      ACCUM: begin
        if (bus.ce_in) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = WAIT;
            stall_d = 1'b1;
          end else begin
            cnt_d = cnt_q + LOG2N'(1);
          end
        end
      end
      WAIT: begin
        state_d   = CAPT;
        sum_clr_d = 1'b1;
      end
      CAPT: begin
        state_d   = ACCUM;
        stall_d   = 1'b0;
        sum_clr_d = 1'b0;
        win_cnt_d = win_cnt_q + 8'd1;
        if (!avg_valid_q || bus.avg_ready) begin
          avg_d       = mean;
          avg_valid_d = 1'b1;
        end else begin
          err_drop_d = 1'b1;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      stall_q     <= 1'b0;
      sum_clr_q   <= 1'b0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      win_cnt_q   <= '0;
      err_drop_q  <= 1'b0;
      err_ce_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_q     <= stall_d;
      sum_clr_q   <= sum_clr_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      win_cnt_q   <= win_cnt_d;
      err_drop_q  <= err_drop_d;
      err_ce_q    <= err_ce_d;
    end
  end

  assign bus.stall     = stall_q;
  assign bus.sum_clr   = sum_clr_q;
  assign bus.avg_out   = avg_q;
  assign bus.avg_valid = avg_valid_q;
  assign bus.win_cnt   = win_cnt_q;
  assign bus.err_drop  = err_drop_q;
  assign bus.err_ce    = err_ce_q;

endmodule

// File: tb/tb_window_averager.sv
// Bench for window_averager with LOG2N=2 and a behavioural two-stage running
// summator in front of it; expected means come from integer floor division.
module tb_window_averager;
  import window_pkg::*;

  localparam int LOG2N = 2;
  localparam int WIN   = 1 << LOG2N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  window_averager_if bus();

  window_averager #(.LOG2N(LOG2N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Summator: ce registers the sample, the next edge adds it into the sum.
  logic signed [SAMPLE_W-1:0] x_in;
  logic signed [SAMPLE_W-1:0] tmp_q;
  logic                       tmp_v;
  logic signed [SUM_W-1:0]    sum_q;

  always_ff @(posedge clk) begin
    if (rst || bus.sum_clr) begin
      tmp_q <= '0;
      tmp_v <= 1'b0;
      sum_q <= '0;
    end else begin
      tmp_q <= x_in;
      tmp_v <= bus.ce_in;
      if (tmp_v) sum_q <= sum_q + SUM_W'(tmp_q);
    end
  end

  assign bus.y_in = sum_q;

  int checks = 0;
  int passes = 0;

  function automatic logic signed [SAMPLE_W-1:0] mean_ref(input int s);
    int q;
    int t;
    t = s;
`ifdef WINDOW_AVERAGER_ROUND_EN
    t = t + WIN / 2;
`endif
    q = t / WIN;
    if ((t % WIN != 0) && (t < 0)) q = q - 1;
    return SAMPLE_W'(q);
  endfunction

  function automatic int rand_sample();
    return int'($urandom_range(8191, 0)) - 4096;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ce_in = 1'b0;
    bus.avg_ready = 1'b0;
    x_in = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic feed(input int vals[WIN]);
    for (int i = 0; i < WIN; i++) begin
      x_in = SAMPLE_W'(vals[i]);
      bus.ce_in = 1'b1;
      tick();
    end
    bus.ce_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.avg_out !== '0) $display("FAIL reset_avg_out: got %0d want 0", bus.avg_out); else passes++;
    checks++; if (bus.avg_valid !== 1'b0) $display("FAIL reset_avg_valid: got %b want 0", bus.avg_valid); else passes++;
    checks++; if (bus.win_cnt !== 8'd0) $display("FAIL reset_win_cnt: got %0d want 0", bus.win_cnt); else passes++;
    checks++; if ({bus.stall, bus.sum_clr, bus.err_drop, bus.err_ce} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000", {bus.stall, bus.sum_clr, bus.err_drop, bus.err_ce}); else passes++;
  endtask

  task automatic test_basic();
    int v[WIN];
    v = '{1, 2, 3, 4};
    feed(v);
    checks++; if ({bus.stall, bus.avg_valid} !== 2'b10) $display("FAIL basic_e0: stall,valid got %b want 10", {bus.stall, bus.avg_valid}); else passes++;
    tick();
    checks++; if (bus.sum_clr !== 1'b1) $display("FAIL basic_sum_clr: got %b want 1", bus.sum_clr); else passes++;
    checks++; if (bus.y_in !== 21'sd10) $display("FAIL basic_y_in: got %0d want 10", bus.y_in); else passes++;
    checks++; if (bus.avg_valid !== 1'b0) $display("FAIL basic_e1_valid: got %b want 0", bus.avg_valid); else passes++;
    tick();
    checks++; if (bus.avg_valid !== 1'b1) $display("FAIL basic_e2_valid: got %b want 1", bus.avg_valid); else passes++;
    checks++; if (bus.avg_out !== mean_ref(10)) $display("FAIL basic_avg: got %0d want %0d", bus.avg_out, mean_ref(10)); else passes++;
    checks++; if ({bus.stall, bus.sum_clr, bus.win_cnt} !== {2'b00, 8'd1})
      $display("FAIL basic_e2_ctrl: stall,clr,cnt got %b want 0000000001", {bus.stall, bus.sum_clr, bus.win_cnt}); else passes++;
    tick();
    checks++; if (bus.y_in !== 21'sd0) $display("FAIL basic_cleared: y_in got %0d want 0", bus.y_in); else passes++;
    checks++; if (bus.sum_clr !== 1'b0) $display("FAIL basic_clr_once: got %b want 0", bus.sum_clr); else passes++;
    bus.avg_ready = 1'b1;
    tick();
    bus.avg_ready = 1'b0;
    checks++; if (bus.avg_valid !== 1'b0) $display("FAIL basic_pop: valid got %b want 0", bus.avg_valid); else passes++;
  endtask

  task automatic test_negative();
    int v[WIN];
    v = '{-1, -1, -1, -2};
    feed(v);
    tick();
    tick();
    checks++; if (bus.avg_out !== mean_ref(-5)) $display("FAIL neg_avg: got %h want %h", bus.avg_out, mean_ref(-5)); else passes++;
    bus.avg_ready = 1'b1;
    tick();
    bus.avg_ready = 1'b0;
  endtask

  task automatic test_extremes();
    int v[WIN];
    do_reset();
    v = '{4095, 4095, 4095, 4095};
    feed(v);
    tick();
    tick();
    checks++; if (bus.avg_out !== 13'sd4095) $display("FAIL ext_max: got %0d want 4095", bus.avg_out); else passes++;
    bus.avg_ready = 1'b1;
    tick();
    bus.avg_ready = 1'b0;
    v = '{-4096, -4096, -4096, -4096};
    feed(v);
    tick();
    tick();
    checks++; if (bus.avg_out !== 13'h1000) $display("FAIL ext_min: got %h want 1000", bus.avg_out); else passes++;
    checks++; if (bus.win_cnt !== 8'd2) $display("FAIL ext_win_cnt: got %0d want 2", bus.win_cnt); else passes++;
    bus.avg_ready = 1'b1;
    tick();
    bus.avg_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int a[WIN];
    int b[WIN];
    int sa;
    sa = 0;
    do_reset();
    for (int i = 0; i < WIN; i++) begin
      a[i] = rand_sample();
      b[i] = rand_sample();
      sa += a[i];
    end
    feed(a);
    tick();
    tick();
    feed(b);
    tick();
    tick();
    checks++; if (bus.avg_out !== mean_ref(sa)) $display("FAIL bp_retained: got %0d want %0d", bus.avg_out, mean_ref(sa)); else passes++;
    checks++; if ({bus.avg_valid, bus.err_drop} !== 2'b11) $display("FAIL bp_flags: valid,drop got %b want 11", {bus.avg_valid, bus.err_drop}); else passes++;
    checks++; if (bus.win_cnt !== 8'd2) $display("FAIL bp_win_cnt: got %0d want 2", bus.win_cnt); else passes++;
    bus.avg_ready = 1'b1;
    tick();
    bus.avg_ready = 1'b0;
    checks++; if ({bus.avg_valid, bus.err_drop} !== 2'b01) $display("FAIL bp_pop: valid,drop got %b want 01", {bus.avg_valid, bus.err_drop}); else passes++;
  endtask

  task automatic test_ce_during_wait();
    int a[WIN];
    int sb;
    sb = 0;
    do_reset();
    for (int i = 0; i < WIN; i++) a[i] = rand_sample();
    feed(a);
    x_in = 13'sd777;
    bus.ce_in = 1'b1;
    tick();
    bus.ce_in = 1'b0;
    checks++; if ({bus.err_ce, bus.stall} !== 2'b11) $display("FAIL cew_err: err_ce,stall got %b want 11", {bus.err_ce, bus.stall}); else passes++;
    tick();
    checks++; if ({bus.stall, bus.avg_valid} !== 2'b01) $display("FAIL cew_e2: stall,valid got %b want 01", {bus.stall, bus.avg_valid}); else passes++;
    bus.avg_ready = 1'b1;
    for (int i = 0; i < WIN - 1; i++) begin
      a[i] = rand_sample();
      sb += a[i];
      x_in = SAMPLE_W'(a[i]);
      bus.ce_in = 1'b1;
      tick();
    end
    checks++; if (bus.stall !== 1'b0) $display("FAIL cew_count: stall after %0d samples got %b want 0", WIN - 1, bus.stall); else passes++;
    a[0] = rand_sample();
    sb += a[0];
    x_in = SAMPLE_W'(a[0]);
    tick();
    bus.ce_in = 1'b0;
    checks++; if (bus.stall !== 1'b1) $display("FAIL cew_count_last: stall got %b want 1", bus.stall); else passes++;
    tick();
    tick();
    checks++; if (bus.avg_out !== mean_ref(sb)) $display("FAIL cew_next_avg: got %0d want %0d", bus.avg_out, mean_ref(sb)); else passes++;
    bus.avg_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    int v[WIN];
    x_in = 13'sd100;
    bus.ce_in = 1'b1;
    tick();
    x_in = 13'sd200;
    tick();
    bus.ce_in = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({bus.avg_valid, bus.win_cnt, bus.err_ce, bus.err_drop, bus.stall} !== 12'b0)
      $display("FAIL midrst_state: valid,cnt,errs,stall got %b want 0", {bus.avg_valid, bus.win_cnt, bus.err_ce, bus.err_drop, bus.stall}); else passes++;
    checks++; if (bus.avg_out !== '0) $display("FAIL midrst_avg_out: got %0d want 0", bus.avg_out); else passes++;
    v = '{8, 8, 8, 8};
    feed(v);
    tick();
    tick();
    checks++; if ({bus.avg_valid, bus.avg_out} !== {1'b1, 13'sd8}) $display("FAIL midrst_avg: valid,avg got %b,%0d want 1,8", bus.avg_valid, bus.avg_out); else passes++;
  endtask

  task automatic test_random();
    int v[WIN];
    int s;
    int n;
    int exp_win;
    exp_win = 0;
    do_reset();
    bus.avg_ready = 1'b1;
    for (int w = 0; w < 12; w++) begin
      s = 0;
      for (int i = 0; i < WIN; i++) begin
        v[i] = rand_sample();
        s += v[i];
        bus.ce_in = 1'b0;
        repeat ($urandom_range(2, 0)) tick();
        x_in = SAMPLE_W'(v[i]);
        bus.ce_in = 1'b1;
        tick();
      end
      bus.ce_in = 1'b0;
      n = 0;
      while (!bus.avg_valid && n < 8) begin
        tick();
        n++;
      end
      exp_win++;
      checks++; if (n !== 2) $display("FAIL rand_latency[%0d]: edges got %0d want 2", w, n); else passes++;
      checks++; if (bus.avg_out !== mean_ref(s)) $display("FAIL rand_avg[%0d]: got %0d want %0d (sum %0d)", w, bus.avg_out, mean_ref(s), s); else passes++;
      checks++; if (bus.win_cnt !== 8'(exp_win)) $display("FAIL rand_win_cnt[%0d]: got %0d want %0d", w, bus.win_cnt, exp_win); else passes++;
    end
    checks++; if ({bus.err_drop, bus.err_ce} !== 2'b00) $display("FAIL rand_errs: drop,ce got %b want 00", {bus.err_drop, bus.err_ce}); else passes++;
    bus.avg_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.ce_in = 1'b0;
    bus.avg_ready = 1'b0;
    x_in = '0;
    test_reset();
    test_basic();
    test_negative();
    test_extremes();
    test_backpressure();
    test_ce_during_wait();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
